// File: rtl/battle_if.sv
// Signal bundle between the battle turn sequencer and its surroundings
// (UART key source, player block, attack bar and damage animation).
interface battle_if;
   logic [7:0]  key;
   logic        isDeath;
   logic        atkPass;
   logic        isDmgComplete;
   logic [7:0]  mstate;
   logic [15:0] playerInstruction;
   logic        isMove;
   logic [7:0]  monHP;
   logic        startDmg;
   logic [7:0]  dmgMon;
   logic [7:0]  damage;
   logic        heal;

   modport master (
      output key, isDeath, atkPass, isDmgComplete,
      input  mstate, playerInstruction, isMove, monHP, startDmg, dmgMon, damage, heal
   );

   modport slave (
      input  key, isDeath, atkPass, isDmgComplete,
      output mstate, playerInstruction, isMove, monHP, startDmg, dmgMon, damage, heal
   );
endinterface

// File: rtl/battle_fsm.sv
// Turn sequencer for the battle game: decodes keypresses, walks menu/attack/
// damage/dodge/end states, tracks monster HP and issues player commands.
//
// state   | meaning
// IDLE    | waiting for space/enter to start a game
// M_FIGHT | menu cursor on FIGHT
// M_ACT   | menu cursor on ACT
// M_ITEM  | menu cursor on ITEM
// M_MERCY | menu cursor on MERCY
// ATTACK  | attack bar running, space commits the hit
// DAMAGE  | damage animation playing on the monster
// DODGE   | player moves while the dodge timer runs
// LOSE    | player died, 'r' restarts
// WIN     | monster defeated or spared, 'r' restarts
module battle_fsm #(
   parameter logic [7:0]  MON_HP_INIT = 8'd100,
   parameter logic [7:0]  ATK_HIT     = 8'd20,
   parameter logic [7:0]  MON_DMG     = 8'd5,
   parameter logic [7:0]  HEAL_AMT    = 8'd10,
   parameter logic [1:0]  ITEM_COUNT  = 2'd3,
   parameter logic [7:0]  SPARE_HP    = 8'd20,
   parameter logic [31:0] DODGE_CYC   = 32'd500000000
) (
   input logic     clk,
   input logic     reset,
   battle_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      M_FIGHT = 4'd1,
      M_ACT   = 4'd2,
      M_ITEM  = 4'd3,
      M_MERCY = 4'd4,
      ATTACK  = 4'd5,
      DAMAGE  = 4'd6,
      DODGE   = 4'd7,
      LOSE    = 4'd8,
      WIN     = 4'd9
   } state_e;

   localparam logic [7:0] K_A     = 8'h61;
   localparam logic [7:0] K_D     = 8'h64;
   localparam logic [7:0] K_W     = 8'h77;
   localparam logic [7:0] K_S     = 8'h73;
   localparam logic [7:0] K_SPACE = 8'h20;
   localparam logic [7:0] K_ENTER = 8'h0D;
   localparam logic [7:0] K_R     = 8'h72;

   localparam logic [7:0] OP_MOVE  = 8'h01;
   localparam logic [7:0] OP_HEAL  = 8'h02;
   localparam logic [7:0] OP_RESET = 8'h03;

   localparam logic [31:0] DODGE_LAST = DODGE_CYC - 32'd1;

   state_e      state, state_nxt;
   logic [7:0]  key_prev;
   logic [7:0]  mon_hp, mon_hp_nxt;
   logic [1:0]  items, items_nxt;
   logic [7:0]  dmg_mon, dmg_nxt;
   logic [15:0] instr, instr_nxt;
   logic        heal_q, heal_nxt;
   logic        start_q, start_nxt;
   logic [31:0] dodge_cnt;
   logic        key_evt;
   logic        in_play;
   logic [7:0]  hit;

   // A held key produces one event: only the first cycle of a new nonzero code counts.
   assign key_evt = (bus.key != 8'd0) && (bus.key != key_prev);
   assign in_play = (state != IDLE) && (state != WIN) && (state != LOSE);
   assign hit     = bus.atkPass ? ATK_HIT : 8'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         key_prev  <= 8'd0;
         mon_hp    <= MON_HP_INIT;
         items     <= ITEM_COUNT;
         dmg_mon   <= 8'd0;
         instr     <= 16'd0;
         heal_q    <= 1'b0;
         start_q   <= 1'b0;
         dodge_cnt <= 32'd0;
      end else begin
         state     <= state_nxt;
         key_prev  <= bus.key;
         mon_hp    <= mon_hp_nxt;
         items     <= items_nxt;
         dmg_mon   <= dmg_nxt;
         instr     <= instr_nxt;
         heal_q    <= heal_nxt;
         start_q   <= start_nxt;
         dodge_cnt <= (state == DODGE) ? dodge_cnt + 32'd1 : 32'd0;
      end
   end

   always_comb begin
      state_nxt  = state;
      mon_hp_nxt = mon_hp;
      items_nxt  = items;
      dmg_nxt    = dmg_mon;
      instr_nxt  = 16'd0;
      heal_nxt   = 1'b0;
      start_nxt  = 1'b0;

      if (in_play && bus.isDeath) begin
         state_nxt = LOSE;
      end else begin
         case (state)
            IDLE: begin
               if (key_evt && (bus.key == K_SPACE || bus.key == K_ENTER)) begin
                  state_nxt = M_FIGHT;
                  instr_nxt = {OP_RESET, 8'd0};
               end
            end
            M_FIGHT, M_ACT, M_ITEM, M_MERCY: begin
               if (key_evt && bus.key == K_D) begin
                  case (state)
                     M_FIGHT: state_nxt = M_ACT;
                     M_ACT:   state_nxt = M_ITEM;
                     M_ITEM:  state_nxt = M_MERCY;
                     default: state_nxt = M_FIGHT;
                  endcase
               end else if (key_evt && bus.key == K_A) begin
                  case (state)
                     M_FIGHT: state_nxt = M_MERCY;
                     M_ACT:   state_nxt = M_FIGHT;
                     M_ITEM:  state_nxt = M_ACT;
                     default: state_nxt = M_ITEM;
                  endcase
               end else if (key_evt && bus.key == K_ENTER) begin
                  case (state)
                     M_FIGHT: state_nxt = ATTACK;
                     M_ACT:   state_nxt = DODGE;
                     M_ITEM: begin
                        if (items != 2'd0) begin
                           heal_nxt  = 1'b1;
                           items_nxt = items - 2'd1;
                           instr_nxt = {OP_HEAL, HEAL_AMT};
                           state_nxt = DODGE;
                        end
                     end
                     default: state_nxt = (mon_hp <= SPARE_HP) ? WIN : DODGE;
                  endcase
               end
            end
            ATTACK: begin
               // HP is charged on the entry edge so DAMAGE can test it directly.
               if (key_evt && bus.key == K_SPACE) begin
                  dmg_nxt    = hit;
                  mon_hp_nxt = (mon_hp < hit) ? 8'd0 : mon_hp - hit;
                  start_nxt  = 1'b1;
                  state_nxt  = DAMAGE;
               end
            end
            DAMAGE: begin
               if (bus.isDmgComplete)
                  state_nxt = (mon_hp == 8'd0) ? WIN : DODGE;
            end
            DODGE: begin
               if (key_evt && (bus.key == K_W || bus.key == K_A ||
                               bus.key == K_S || bus.key == K_D))
                  instr_nxt = {OP_MOVE, bus.key};
               if (dodge_cnt == DODGE_LAST)
                  state_nxt = M_FIGHT;
            end
            LOSE, WIN: begin
               if (key_evt && bus.key == K_R) begin
                  state_nxt  = IDLE;
                  mon_hp_nxt = MON_HP_INIT;
                  items_nxt  = ITEM_COUNT;
                  dmg_nxt    = 8'd0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.mstate            = {4'd0, state};
   assign bus.playerInstruction = instr;
   assign bus.isMove            = (state == DODGE);
   assign bus.monHP             = mon_hp;
   assign bus.startDmg          = start_q;
   assign bus.dmgMon            = dmg_mon;
   assign bus.damage            = MON_DMG;
   assign bus.heal              = heal_q;

endmodule

// File: tb/tb_battle_fsm.sv
// Scoreboard bench for battle_fsm: expected state changes, command words and
// damage events are queued by the stimulus and popped by an output monitor.
module tb_battle_fsm;

   logic clk = 1'b0;
   logic reset = 1'b0;
   battle_if bus();

   battle_fsm #(.DODGE_CYC(32'd8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int heal_seen = 0;
   int mhp = 100;

   logic [7:0]  q_state[$];
   logic [16:0] q_instr[$];
   logic [15:0] q_dmg[$];
   logic [7:0]  last_state = 8'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Output monitor: consumes expectations whenever the DUT shows an event.
   always @(negedge clk) begin
      if (!reset) begin
         last_state = 8'd0;
      end else begin
         if (bus.mstate != last_state) begin
            if (q_state.size() == 0) chk("unexpected_state", bus.mstate, last_state);
            else chk("state", bus.mstate, q_state.pop_front());
            last_state = bus.mstate;
         end
         if (bus.playerInstruction != 16'd0 || bus.heal) begin
            if (bus.heal) heal_seen++;
            if (q_instr.size() == 0) chk("unexpected_instr", {bus.heal, bus.playerInstruction}, 17'd0);
            else chk("instr", {bus.heal, bus.playerInstruction}, q_instr.pop_front());
         end
         if (bus.startDmg) begin
            if (q_dmg.size() == 0) chk("unexpected_startDmg", {bus.dmgMon, bus.monHP}, 16'd0);
            else chk("dmg", {bus.dmgMon, bus.monHP}, q_dmg.pop_front());
         end
      end
   end

   task automatic ps(input logic [7:0] s);
      q_state.push_back(s);
   endtask

   task automatic press(input logic [7:0] k);
      @(posedge clk); #1 bus.key = k;
      @(posedge clk); #1 bus.key = 8'd0;
   endtask

   task automatic wait_state(input logic [7:0] s, input int budget);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.mstate != s && n < budget);
      chk("wait_state", bus.mstate, s);
   endtask

   // From M_FIGHT: go to ITEM and select it; returns in M_FIGHT.
   task automatic use_item(input bit avail);
      ps(8'd4); press(8'h61);
      ps(8'd3); press(8'h61);
      if (avail) begin
         ps(8'd7); q_instr.push_back({1'b1, 16'h020A}); press(8'h0D);
         q_instr.push_back({1'b0, 16'h0177}); press(8'h77);
         ps(8'd1); wait_state(8'd1, 30);
      end else begin
         press(8'h0D);
         @(posedge clk); #1;
         chk("item_empty_stay", bus.mstate, 8'd3);
         ps(8'd4); press(8'h64);
         ps(8'd1); press(8'h64);
      end
   endtask

   // From M_FIGHT: attack with the given bar result; returns in M_FIGHT or WIN.
   task automatic attack(input bit pass);
      logic [7:0] d;
      d = pass ? 8'd20 : 8'd0;
      ps(8'd5); press(8'h0D);
      bus.atkPass = pass;
      mhp = (mhp < d) ? 0 : mhp - d;
      ps(8'd6); q_dmg.push_back({d, 8'(mhp)});
      ps((mhp == 0) ? 8'd9 : 8'd7);
      press(8'h20);
      if (mhp != 0) begin
         ps(8'd1); wait_state(8'd1, 40);
      end else begin
         wait_state(8'd9, 10);
      end
   endtask

   initial begin
      int n;
      bus.key = 8'd0; bus.isDeath = 1'b0; bus.atkPass = 1'b0; bus.isDmgComplete = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mstate", bus.mstate, 8'd0);
      chk("rst_monHP", bus.monHP, 8'd100);
      chk("rst_instr", bus.playerInstruction, 16'd0);
      chk("rst_outs", {bus.isMove, bus.startDmg, bus.heal, bus.dmgMon}, 11'd0);
      chk("damage_const", bus.damage, 8'd5);
      reset = 1'b1;

      // Start, attack with a pass, damage waits on animation, dodge timing
      ps(8'd1); q_instr.push_back({1'b0, 16'h0300}); press(8'h20);
      ps(8'd5); press(8'h0D);
      bus.atkPass = 1'b1;
      ps(8'd6); q_dmg.push_back({8'd20, 8'd80}); press(8'h20);
      mhp = 80;
      @(posedge clk); #1; @(posedge clk); #1;
      chk("damage_hold", bus.mstate, 8'd6);
      ps(8'd7); bus.isDmgComplete = 1'b1;
      wait_state(8'd7, 5);
      bus.isDmgComplete = 1'b0;
      chk("dodge_isMove", bus.isMove, 1'b1);
      ps(8'd1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.mstate == 8'd7 && n < 50);
      chk("dodge_cycles", n, 8);
      chk("menu_isMove", bus.isMove, 1'b0);

      // Menu wrap and held key
      ps(8'd4); press(8'h61);
      ps(8'd1); press(8'h64);
      ps(8'd2);
      @(posedge clk); #1 bus.key = 8'h64;
      repeat (10) @(posedge clk);
      #1 bus.key = 8'd0;
      chk("held_key_one_step", bus.mstate, 8'd2);
      ps(8'd1); press(8'h61);

      // Items: three heals then empty
      use_item(1'b1); use_item(1'b1); use_item(1'b1); use_item(1'b0);

      // Death in M_ACT, restart restores state
      ps(8'd2); press(8'h64);
      ps(8'd8); bus.isDeath = 1'b1;
      wait_state(8'd8, 5);
      bus.isDeath = 1'b0;
      press(8'h64);
      ps(8'd0); press(8'h72);
      mhp = 100;
      chk("restart_monHP", bus.monHP, 8'd100);
      chk("restart_dmgMon", bus.dmgMon, 8'd0);
      ps(8'd1); q_instr.push_back({1'b0, 16'h0300}); press(8'h0D);
      use_item(1'b1);

      // Mercy at full HP falls through to dodge
      ps(8'd4); press(8'h61);
      ps(8'd7); press(8'h0D);
      ps(8'd1); wait_state(8'd1, 30);

      bus.isDmgComplete = 1'b1;
      attack(1'b0);
      repeat (4) attack(1'b1);
      chk("hp_before_mercy", bus.monHP, 8'd20);
      ps(8'd4); press(8'h61);
      ps(8'd9); press(8'h0D);
      wait_state(8'd9, 5);
      ps(8'd0); press(8'h72);
      mhp = 100;
      ps(8'd1); q_instr.push_back({1'b0, 16'h0300}); press(8'h20);

      // Kill the monster: HP saturates to 0 and DAMAGE goes to WIN
      repeat (5) attack(1'b1);
      chk("win_monHP", bus.monHP, 8'd0);
      ps(8'd0); press(8'h72);
      ps(8'd1); q_instr.push_back({1'b0, 16'h0300}); press(8'h20);

      // Asynchronous reset in the middle of a dodge
      ps(8'd4); press(8'h61);
      ps(8'd7); press(8'h0D);
      wait_state(8'd7, 5);
      @(posedge clk); #3 reset = 1'b0;
      #1;
      chk("async_rst_mstate", bus.mstate, 8'd0);
      chk("async_rst_monHP", bus.monHP, 8'd100);
      chk("async_rst_isMove", bus.isMove, 1'b0);
      chk("async_rst_instr", bus.playerInstruction, 16'd0);
      @(posedge clk); #1;

      chk("pending_state", q_state.size(), 0);
      chk("pending_instr", q_instr.size(), 0);
      chk("pending_dmg", q_dmg.size(), 0);
      chk("heal_pulses", heal_seen, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
